// File: rtl/oin_portal_pkg.sv
// oin_portal_pkg: Oin portal framing constants and types.
// The indication serializer and the request decoder both import this package.
package oin_portal_pkg;
  localparam logic [15:0] OIN_IND_HEARD = 16'd0;
  localparam logic [15:0] OIN_REQ_SAY   = 16'd0;
  localparam int HDR_ID_W      = 16;
  localparam int HDR_SEQ_W     = 8;
  localparam int HDR_LEN_W     = 8;
  localparam int OIN_PAY_WIDTH = 128;
  typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/m2p_oin_indication_ser.sv
// m2p_oin_indication_ser: frames heard(v) calls as a header beat plus payload beats on the enq pipe.
// The argument register shifts down one beat per payload beat, so the beat mux stays a two-way choice.
module m2p_oin_indication_ser
  import oin_portal_pkg::*;
#(
  parameter int                    ARG_WIDTH = 32,
  parameter int                    PAY_WIDTH = OIN_PAY_WIDTH,
  parameter int                    OUT_WIDTH = 32,
  parameter logic [HDR_ID_W-1:0]   METHOD_ID = OIN_IND_HEARD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 heard__ENA,
  input  logic [ARG_WIDTH-1:0] heard_v,
  output logic                 heard__RDY,
  output logic                 pipe_enq__ENA,
  output logic [OUT_WIDTH-1:0] pipe_enq_v,
  input  logic                 pipe_enq__RDY
);
  localparam int NPAY   = PAY_WIDTH / OUT_WIDTH;
  localparam int NBEATS = NPAY + 1;
  localparam int BW     = $clog2(NBEATS);
  localparam logic [HDR_LEN_W-1:0] LEN = HDR_LEN_W'(NPAY);
  state_e                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [HDR_SEQ_W-1:0]   seq_q, seq_d;
  logic [PAY_WIDTH-1:0]   arg_q, arg_d;
  logic                   last;
  assign last = beat_q == BW'(NBEATS - 1);
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    seq_d = seq_q;
    arg_d = arg_q;
    heard__RDY = state_q == IDLE;
    pipe_enq__ENA = state_q == SEND && pipe_enq__RDY;
    pipe_enq_v = state_q == IDLE ? '0 :
                 beat_q == '0 ? OUT_WIDTH'({METHOD_ID, seq_q, LEN}) : arg_q[OUT_WIDTH-1:0];
    if (state_q == IDLE && heard__ENA) begin
      state_d = SEND;
      beat_d = '0;
      arg_d = PAY_WIDTH'(heard_v);
    end
    if (pipe_enq__ENA) begin
      beat_d = last ? '0 : beat_q + 1'b1;
      if (beat_q != '0) arg_d = arg_q >> OUT_WIDTH;
      if (last) begin
        state_d = IDLE;
        seq_d = seq_q + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q <= '0;
      seq_q <= '0;
      arg_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      seq_q <= seq_d;
      arg_q <= arg_d;
    end
  end
  // A call strobe while busy is ignored by the FSM; flag it in simulation.
  heard_ena_while_busy: assert property (@(posedge CLK) disable iff (RST) heard__ENA |-> heard__RDY);
endmodule
